regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port `clk`, reset port `rst`.
REQ-002 Parameter DATA_W, default 32: word width in bits.
REQ-003 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-004 Parameter NUM_RD, default 2: number of read ports, legal range 1..4.
REQ-005 Parameter ZERO_REG, default 1: 1 means entry 0 is hardwired to zero.
REQ-006 The ports SHALL be exactly:
  - clk  input  1  clock, all state on rising edge
  - rst  input  1  synchronous active-high reset
  - clr_req  input  1  request a full-array clear
  - busy  output  1  clear in progress
  - rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
  - rd_data  output  NUM_RD*DATA_W  packed registered read data, same packing
  - we  input  1  write enable
  - wr_addr  input  ADDR_W  write address
  - wr_data  input  DATA_W  write data

Function
REQ-007 Each read port SHALL register R[rd_addr_k] on the rising edge: one-cycle latency, with all ports independent.
REQ-008 In IDLE, a write with we=1 SHALL update R[wr_addr] on the rising edge.
REQ-009 With ZERO_REG=1:
  - writes to address 0 SHALL be dropped;
  - reads of address 0 SHALL return 0.
REQ-010 The clear FSM SHALL have two states, IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1, with counter loaded to 0;
  - in CLEAR, each cycle writes 0 to R[counter] and increments the counter;
  - CLEAR -> IDLE after entry DEPTH-1 is cleared, taking exactly DEPTH cycles.
REQ-011 busy SHALL be 1 exactly while the FSM is in CLEAR, as a registered output.
REQ-012 While busy=1:
  - writes SHALL be ignored;
  - rd_data SHALL be driven 0 on every port.
REQ-013 clr_req asserted while busy=1 SHALL be ignored and SHALL NOT restart the counter.
REQ-014 clr_req=1 together with we=1 in IDLE SHALL take priority: the FSM enters CLEAR and the write is dropped.
REQ-015 The counter SHALL be ADDR_W bits wide and SHALL NOT wrap into a second pass; the terminal count is DEPTH-1.
REQ-016 Two or more read ports addressing the same entry SHALL all return identical data.

Reset
REQ-017 On rst=1 at a rising edge:
  - the FSM SHALL enter CLEAR with counter 0 and busy=1;
  - all rd_data SHALL be 0.
  The array is therefore zeroed in DEPTH cycles after reset deasserts.
REQ-018 rst asserted mid-clear SHALL restart the clear from entry 0.
REQ-019 rst SHALL have priority over clr_req and we.

Configuration
REQ-020 Macro REGFILE_BYPASS_EN controls same-cycle read/write behaviour:
  - defined: write-first. A read port whose address equals wr_addr while we=1 in IDLE registers wr_data, except address 0 when ZERO_REG=1.
  - undefined: read-first. The port registers the old entry content.

Structure
REQ-021 Package regfile_pkg SHALL hold:
  - the FSM state typedef (IDLE, CLEAR);
  - default-parameter constants for DATA_W, ADDR_W and NUM_RD.
REQ-022 The clear FSM and counter SHALL be a sub-module, regfile_clr_fsm, with outputs busy, clr_we and clr_addr. The array, read ports and bypass logic remain in regfile_mp.

Verification
REQ-023 Reset and clear: pulse rst, then read every address -> busy high for exactly 32 cycles, then all reads return 0x00000000.
REQ-024 Write and read: write 0xDEADBEEF to address 7, then read it on ports 0 and 1 the next cycle -> both ports return 0xDEADBEEF one cycle after the address is applied.
REQ-025 Zero register: write 0x12345678 to address 0 with ZERO_REG=1 -> reading address 0 returns 0.
REQ-026 Same-cycle read/write: read address 3 while writing 0xA5A5A5A5 to address 3, with old value 0x1 ->
  - returns 0xA5A5A5A5 with REGFILE_BYPASS_EN defined;
  - returns 0x00000001 without it.
REQ-027 Clear priority: assert clr_req and we to address 5 in the same cycle, then write while busy=1 -> both writes are dropped and address 5 reads 0 after clear completes.
REQ-028 Reset mid-clear: assert rst at cycle 10 of a clear -> busy remains high for a further 32 cycles after rst deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN (write-first reads).
package regfile_pkg;

  // Clear sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every entry once, issuing a zero write per cycle.
// busy is registered and is high exactly while the sequencer is in CLEAR.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  // State, counter and busy flag; reset starts a clear from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // Requests during a clear are ignored; the counter stops at the
          // last entry instead of wrapping into a second pass.
          if (r_cnt == LAST_ADDR) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign clr_we   = r_busy;
  assign clr_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, one write port,
// optional hardwired-zero entry 0 and a self-sequenced full-array clear.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem     [DEPTH];
  logic [DATA_W-1:0] r_rd_p1   [NUM_RD];
  logic [DATA_W-1:0] w_rd_next [NUM_RD];
  logic [ADDR_W-1:0] w_rd_addr [NUM_RD];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_start;
  logic              w_zero_wa;
  logic              w_usr_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign busy        = w_busy;
  assign w_clr_start = clr_req & ~w_busy;
  assign w_zero_wa   = (ZERO_REG != 0) && (wr_addr == '0);
  // A user write only lands in IDLE, loses to reset and to a clear request,
  // and never touches the hardwired zero entry.
  assign w_usr_we    = we & ~w_busy & ~clr_req & ~rst & ~w_zero_wa;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    assign w_rd_addr[k]                 = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W]  = r_rd_p1[k];
  end

  // Write port mux: the clear sequencer owns the array while busy
  always_comb begin
    w_mem_we   = w_usr_we;
    w_mem_addr = wr_addr;
    w_mem_data = wr_data;
    if (w_busy) begin
      w_mem_we   = w_clr_we;
      w_mem_addr = w_clr_addr;
      w_mem_data = '0;
    end
  end

  // Array storage update
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Next read data per port, with optional write-first forwarding
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_next[k] = r_mem[w_rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
      if (w_usr_we && (w_rd_addr[k] == wr_addr)) begin
        w_rd_next[k] = wr_data;
      end
`endif
      if ((ZERO_REG != 0) && (w_rd_addr[k] == '0)) begin
        w_rd_next[k] = '0;
      end
    end
  end

  // ---- stage p1: registered read ports ----
  // Outputs read zero from the edge that starts a clear until it finishes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_RD; k++) begin
      if (rst || w_busy || w_clr_start) begin
        r_rd_p1[k] <= '0;
      end else begin
        r_rd_p1[k] <= w_rd_next[k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters, 2 read ports).
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
  localparam bit ZR    = 1'b1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_req = 1'b0;
  logic             busy;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic             we = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Reference model: array contents as seen by software plus clear cycles left.
  // A clear zeroes the model array at once: stale entries cannot be observed
  // while busy since reads return 0 and writes are dropped.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;
  logic [DW-1:0] e_rd [NR];
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < NR; k++) e_rd[k] = '0;
  endtask

  // One clock: drive inputs, advance the model, check busy and all ports.
  task automatic step(input bit r, input bit c, input bit w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0] ra [NR];
    bit            wr_ok;
    @(negedge clk);
    rst = r; clr_req = c; we = w; wr_addr = wa; wr_data = wd;
    rd_addr = {a1, a0};
    ra[0] = a0; ra[1] = a1;
    wr_ok = w && !(ZR && (wa == 0));
    if (r) begin
      m_left = DEPTH; model_clear();
    end else if (m_left > 0) begin
      m_left--;
      for (int k = 0; k < NR; k++) e_rd[k] = '0;
    end else if (c) begin
      m_left = DEPTH; model_clear();
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (ZR && (ra[k] == 0))              e_rd[k] = '0;
        else if (BYP && wr_ok && ra[k] == wa) e_rd[k] = wd;
        else                                  e_rd[k] = m_mem[ra[k]];
      end
      if (wr_ok) m_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("rd0", rd_data[0 +: DW], e_rd[0]);
    chk("rd1", rd_data[DW +: DW], e_rd[1]);
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(1'b0, 1'b0, 1'b0, '0, '0, a0, a1);
  endtask

  initial begin
    int cnt;
    model_clear();

    // Reset and first clear: busy for exactly DEPTH cycles
    step(1'b1, 1'b0, 1'b0, '0, '0, 5'd1, 5'd2);
    cnt = 0;
    for (int i = 0; i < DEPTH + 8 && busy; i++) begin
      cnt++;
      idle(5'd4, 5'd9);
    end
    chk("reset_busy_cycles", cnt, DEPTH);

    // Every address reads zero after the clear
    for (int a = 0; a < DEPTH; a++) idle(a[AW-1:0], 5'(DEPTH - 1 - a));

    // Write then read on both ports
    step(1'b0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0);
    idle(5'd7, 5'd7);
    chk("wr7_port0", rd_data[0 +: DW], 32'hDEADBEEF);
    chk("wr7_port1", rd_data[DW +: DW], 32'hDEADBEEF);

    // Hardwired zero entry
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'h12345678, 5'd7, 5'd0);
    idle(5'd0, 5'd0);
    chk("zero_reg", rd_data[0 +: DW], 32'h0);

    // Same-cycle read/write
    step(1'b0, 1'b0, 1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    chk("rw_same", rd_data[0 +: DW], BYP ? 32'hA5A5A5A5 : 32'h00000001);
    idle(5'd3, 5'd7);
    chk("rw_after", rd_data[0 +: DW], 32'hA5A5A5A5);

    // Clear beats a simultaneous write; writes during busy are dropped
    step(1'b0, 1'b0, 1'b1, 5'd5, 32'h0BADF00D, 5'd0, 5'd0);
    idle(5'd5, 5'd7);
    step(1'b0, 1'b1, 1'b1, 5'd5, 32'h11111111, 5'd5, 5'd5);
    for (int i = 0; i < DEPTH + 8 && busy; i++)
      step(1'b0, (i % 3) == 0, 1'b1, 5'd5, 32'h22222222 + i, 5'd5, 5'd7);
    chk("clr_done", {31'd0, busy}, 32'd0);
    idle(5'd5, 5'd7);
    chk("clr_addr5", rd_data[0 +: DW], 32'h0);
    chk("clr_addr7", rd_data[DW +: DW], 32'h0);

    // Reset at cycle 10 of a clear restarts it from entry 0
    step(1'b0, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 5'd9, 5'd9);
    for (int i = 0; i < 9; i++) idle(5'd9, 5'd1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 5'd9, 5'd9);
    cnt = 0;
    for (int i = 0; i < DEPTH + 8 && busy; i++) begin
      cnt++;
      idle(5'd9, 5'd2);
    end
    chk("rst_mid_busy_cycles", cnt, DEPTH);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(255) == 0), ($urandom_range(63) == 0), $urandom_range(1) == 1,
           5'($urandom_range(DEPTH - 1)), $urandom,
           5'($urandom_range(DEPTH - 1)), 5'($urandom_range(DEPTH - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
